// File: rtl/c1s2_input_loader_if.sv
// Bus bundle for c1s2_input_loader.
// Groups the host write port, the five kernel-row read ports, the layer
// handshake and the status flags. clk and rst_n stay plain module ports.
//   master : host/sequencer side (drives en, we, wr_addr, din, rd_addr_5P,
//            work_finished)
//   slave  : loader side (drives rd_data_5P, layer_en, busy, done,
//            wr_drop, err_addr)
interface c1s2_input_loader_if #(
  parameter int unsigned DATA_W = 16
);
  logic                  en;
  logic                  we;
  logic [31:0]           wr_addr;
  logic [DATA_W-1:0]     din;
  logic [159:0]          rd_addr_5P;
  logic [5*DATA_W-1:0]   rd_data_5P;
  logic                  layer_en;
  logic                  work_finished;
  logic                  busy;
  logic                  done;
  logic                  wr_drop;
  logic                  err_addr;

  modport master (
    output en, we, wr_addr, din, rd_addr_5P, work_finished,
    input  rd_data_5P, layer_en, busy, done, wr_drop, err_addr
  );

  modport slave (
    input  en, we, wr_addr, din, rd_addr_5P, work_finished,
    output rd_data_5P, layer_en, busy, done, wr_drop, err_addr
  );
endinterface

// File: rtl/c1s2_input_loader.sv
// Input staging block ahead of the C1S2 layer.
// Stores the host image write stream into five replicated banks and serves
// five independent registered read ports (one-cycle latency, read-first).
// Sequences the layer: IDLE -> LOAD -> RUN (layer_en) -> DONE (done pulse).
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : c1s2_input_loader_if.slave (host write, 5 read ports,
//            layer handshake, status flags)
//
// Optional feature macro: C1S2_LOADER_ADDR_CHECK_EN
//   defined   : out-of-range writes are dropped and flagged on err_addr,
//               out-of-range reads return 0
//   undefined : addresses are truncated to IDX_W bits, err_addr tied 0
module c1s2_input_loader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 6144,
  parameter int unsigned IDX_W  = 13
) (
  input logic               clk,
  input logic               rst_n,
  c1s2_input_loader_if.slave bus
);

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_drop_q;
  logic               wr_ok;
  logic               wr_open;
  logic [IDX_W-1:0]   wr_idx;

  logic [NUM_PORTS-1:0][IDX_W-1:0]  rd_idx;
  logic [NUM_PORTS-1:0]             rd_oor;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rd_q;

  // Replicated storage: one copy per read port, identical contents.
  logic [DATA_W-1:0] mem [NUM_PORTS][DEPTH];

  assign wr_open = (state_q == StIdle) || (state_q == StLoad);
  assign wr_idx  = bus.wr_addr[IDX_W-1:0];

`ifdef C1S2_LOADER_ADDR_CHECK_EN
  logic err_addr_q;
  logic wr_in_range;

  assign wr_in_range = (bus.wr_addr < DEPTH);
  assign wr_ok       = bus.we && bus.en && wr_open && wr_in_range;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_idx[p] = bus.rd_addr_5P[32*p +: IDX_W];
      rd_oor[p] = (bus.rd_addr_5P[32*p +: 32] >= DEPTH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr_q <= 1'b0;
    end else if (bus.we && bus.en && wr_open && !wr_in_range) begin
      err_addr_q <= 1'b1;
    end
  end

  assign bus.err_addr = err_addr_q;
`else
  logic unused_addr_bits;

  assign wr_ok = bus.we && bus.en && wr_open;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_idx[p] = bus.rd_addr_5P[32*p +: IDX_W];
      rd_oor[p] = 1'b0;
    end
  end

  // Upper address bits are intentionally ignored in the truncating build.
  always_comb begin
    unused_addr_bits = ^bus.wr_addr[31:IDX_W];
    for (int p = 0; p < NUM_PORTS; p++) begin
      unused_addr_bits = unused_addr_bits ^ (^bus.rd_addr_5P[32*p+IDX_W +: 32-IDX_W]);
    end
  end

  assign bus.err_addr = 1'b0;
`endif

  // Bank write: same index in every copy.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        mem[p][wr_idx] <= bus.din;
      end
    end
  end

  // Registered reads; non-blocking update gives read-first on collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rd_q[p] <= rd_oor[p] ? '0 : mem[p][rd_idx[p]];
      end
    end
  end

  assign bus.rd_data_5P = rd_q;

  // Sequencer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.en) begin
      // Soft abort: bank contents survive, load progress does not.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StLoad: begin
          if (wr_ok) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CNT_W'(DEPTH - 1)) ? StRun : StLoad;
          end
        end
        StRun: begin
          if (bus.work_finished) begin
            state_d = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Moore outputs; layer_en follows the async-reset state register.
  assign bus.layer_en = (state_q == StRun);
  assign bus.busy     = (state_q == StLoad) || (state_q == StRun);
  assign bus.done     = (state_q == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_drop_q <= 1'b0;
    end else if ((state_q == StRun) && bus.we && bus.en) begin
      wr_drop_q <= 1'b1;
    end
  end

  assign bus.wr_drop = wr_drop_q;

endmodule

// File: tb/tb_c1s2_input_loader.sv
// Self-checking bench for c1s2_input_loader: table-driven read vectors plus
// directed sequences for load, completion, abort, collision and reset.
module tb_c1s2_input_loader;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 6144;

  logic clk;
  logic rst_n;

  c1s2_input_loader_if #(.DATA_W(DATA_W)) bus ();

  c1s2_input_loader #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (13)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  typedef struct packed {
    logic [4:0][31:0] addr;
    logic [4:0][15:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rd_port(input int p);
    logic [5*DATA_W-1:0] all;
    all = bus.rd_data_5P;
    return all[p*DATA_W +: DATA_W];
  endfunction

  task automatic set_rd(input int p, input logic [31:0] a);
    bus.rd_addr_5P[32*p +: 32] = a;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic early;
    checks   = 0;
    failures = 0;
    bus.en            = 1'b0;
    bus.we            = 1'b0;
    bus.wr_addr       = '0;
    bus.din           = '0;
    bus.rd_addr_5P    = '0;
    bus.work_finished = 1'b0;

    // Read vectors, expected data from the first load (din = addr + 10000).
    for (int p = 0; p < 5; p++) begin
      vecs[0].addr[p] = 32'(5 + p);
      vecs[0].exp[p]  = 16'(10005 + p);
      vecs[1].addr[p] = 32'(p);
      vecs[1].exp[p]  = 16'(10000 + p);
      vecs[2].addr[p] = 32'(DEPTH - 1 - p);
      vecs[2].exp[p]  = 16'(10000 + DEPTH - 1 - p);
    end
    vecs[3].addr = {32'd0, 32'd2048, 32'd6143, 32'd1, 32'd4095};
    vecs[3].exp  = {16'd10000, 16'd12048, 16'd16143, 16'd10001, 16'd14095};

    // Reset
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_layer_en", 32'(bus.layer_en), 32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_done",     32'(bus.done),     32'd0);
    chk("rst_wr_drop",  32'(bus.wr_drop),  32'd0);
    chk("rst_err_addr", 32'(bus.err_addr), 32'd0);
    chk("rst_rd_data",  32'(bus.rd_data_5P == '0), 32'd1);
    #2 rst_n = 1'b1;
    bus.en = 1'b1;
    step();

`ifdef C1S2_LOADER_ADDR_CHECK_EN
    bus.we      = 1'b1;
    bus.wr_addr = 32'd6144;
    bus.din     = 16'hDEAD;
    step();
    bus.we = 1'b0;
    chk("oor_err_addr", 32'(bus.err_addr), 32'd1);
    chk("oor_not_counted_busy", 32'(bus.busy), 32'd0);
    set_rd(0, 32'd7000);
    step();
    chk("oor_read_zero", 32'(rd_port(0)), 32'd0);
`endif

    // Full load
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus.we      = 1'b1;
      bus.wr_addr = 32'(i);
      bus.din     = 16'(10000 + i);
      step();
      if (i == 0) chk("load_busy", 32'(bus.busy), 32'd1);
      if (i == int'(DEPTH) - 2) chk("load_pre_last_layer_en", 32'(bus.layer_en), 32'd0);
    end
    bus.we = 1'b0;
    chk("load_layer_en", 32'(bus.layer_en), 32'd1);
    chk("run_busy",      32'(bus.busy),     32'd1);
`ifndef C1S2_LOADER_ADDR_CHECK_EN
    chk("err_addr_tied", 32'(bus.err_addr), 32'd0);
`endif

    // Table-driven reads in RUN
    for (int v = 0; v < 4; v++) begin
      bus.rd_addr_5P = vecs[v].addr;
      step();
      for (int p = 0; p < 5; p++) begin
        chk($sformatf("vec%0d_port%0d", v, p), 32'(rd_port(p)), 32'(vecs[v].exp[p]));
      end
    end

    // Write during RUN is dropped
    bus.we      = 1'b1;
    bus.wr_addr = 32'd0;
    bus.din     = 16'h1234;
    set_rd(0, 32'd0);
    step();
    bus.we = 1'b0;
    chk("run_wr_drop", 32'(bus.wr_drop), 32'd1);
    step();
    chk("run_wr_not_stored", 32'(rd_port(0)), 32'd10000);
    chk("run_still_layer_en", 32'(bus.layer_en), 32'd1);

    // Completion
    bus.work_finished = 1'b1;
    step();
    bus.work_finished = 1'b0;
    chk("done_pulse",    32'(bus.done),     32'd1);
    chk("done_layer_en", 32'(bus.layer_en), 32'd0);
    chk("done_busy",     32'(bus.busy),     32'd0);
    step();
    chk("idle_done_low", 32'(bus.done),     32'd0);
    chk("idle_busy",     32'(bus.busy),     32'd0);
    chk("wr_drop_sticky", 32'(bus.wr_drop), 32'd1);

    // work_finished outside RUN is ignored
    bus.work_finished = 1'b1;
    step();
    bus.work_finished = 1'b0;
    chk("wf_idle_done", 32'(bus.done), 32'd0);
    chk("wf_idle_busy", 32'(bus.busy), 32'd0);

    // Abort after 3000 writes
    for (int i = 0; i < 3000; i++) begin
      bus.we      = 1'b1;
      bus.wr_addr = 32'(i);
      bus.din     = 16'(20000 + i);
      step();
    end
    bus.we = 1'b0;
    chk("abort_pre_busy", 32'(bus.busy), 32'd1);
    bus.en = 1'b0;
    step();
    chk("abort_busy",     32'(bus.busy),     32'd0);
    chk("abort_layer_en", 32'(bus.layer_en), 32'd0);
    bus.en = 1'b1;
    step();

    // Reload with a read-first collision at address 7 on port 2
    early = 1'b0;
    set_rd(2, 32'd7);
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus.we      = 1'b1;
      bus.wr_addr = 32'(i);
      bus.din     = (i == 7) ? 16'hBEEF : 16'(30000 + i);
      step();
      if (i == 7) chk("collide_old", 32'(rd_port(2)), 32'd20007);
      if (i == 8) chk("collide_new", 32'(rd_port(2)), 32'hBEEF);
      if ((i < int'(DEPTH) - 1) && bus.layer_en) early = 1'b1;
    end
    bus.we = 1'b0;
    chk("reload_no_early_run", 32'(early),        32'd0);
    chk("reload_layer_en",     32'(bus.layer_en), 32'd1);

    set_rd(0, 32'd100);
    set_rd(1, 32'd2999);
    step();
    chk("reload_rd_100",  32'(rd_port(0)), 32'd30100);
    chk("reload_rd_2999", 32'(rd_port(1)), 32'd32999);

    // Asynchronous reset in RUN
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("areset_layer_en", 32'(bus.layer_en), 32'd0);
    chk("areset_busy",     32'(bus.busy),     32'd0);
    chk("areset_wr_drop",  32'(bus.wr_drop),  32'd0);
    chk("areset_rd_data",  32'(bus.rd_data_5P == '0), 32'd1);
    #10 rst_n = 1'b1;
    step();
    chk("post_reset_busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
